// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for an asyn_fifo.
// Shares one FIFO write port among NUM_REQ requesters that all run in the
// FIFO write-clock domain. A grant lasts up to MAX_BURST accepted words, or
// until the owner drops its request. The next owner is then chosen in the
// same cycle, so back-to-back bursts have no idle cycle between them.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       ack,
   output logic [NUM_REQ-1:0]       gnt,
   input  logic                     wfull,
   output logic                     winc,
   output logic [WIDTH-1:0]         wdata,
   output logic                     busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]   burst_cnt;

   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   next_ptr;
   logic               owner_req;
   logic               burst_end;
   logic [NUM_REQ-1:0] rearb;

   // First set bit of r, searching circularly upward from start; one-hot or zero.
   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [PTR_W-1:0]   start);
      logic [NUM_REQ-1:0] pick;
      logic               found;
      logic [PTR_W-1:0]   idx;
      pick  = '0;
      found = 1'b0;
      idx   = start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && r[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
         idx = (idx == LAST_PTR) ? '0 : idx + 1'b1;
      end
      return pick;
   endfunction

   // Decode the current owner and route its data; wdata is zero with no grant.
   always_comb begin
      owner = '0;
      wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            owner = PTR_W'(i);
            wdata = wdata | req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Write handshake, burst termination and same-cycle re-arbitration.
   always_comb begin
      owner_req = |(req & gnt);
      busy      = (state == BURST);
      winc      = busy & owner_req & ~wfull;
      ack       = winc ? gnt : '0;
      burst_end = busy & ((winc & (burst_cnt == LAST_CNT)) | ~owner_req);
      next_ptr  = (owner == LAST_PTR) ? '0 : owner + 1'b1;
      rearb     = rr_pick(req, next_ptr);
   end

   // Grant state machine: IDLE arbitrates, BURST counts writes and hands over.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         gnt       <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= rr_pick(req, rr_ptr);
                  burst_cnt <= '0;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (burst_end) begin
                  rr_ptr    <= next_ptr;
                  burst_cnt <= '0;
                  if (|rearb) begin
                     gnt <= rearb;
                  end else begin
                     gnt   <= '0;
                     state <= IDLE;
                  end
               end else if (winc) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector tables with a scoreboard queue,
// plus a record of every word written into the FIFO.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           rstn;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   ack;
   logic [N-1:0]   gnt;
   logic           wfull;
   logic           winc;
   logic [W-1:0]   wdata;
   logic           busy;

   fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .gnt      (gnt),
      .wfull    (wfull),
      .winc     (winc),
      .wdata    (wdata),
      .busy     (busy)
   );

   typedef struct {
      logic [3:0] req;
      logic       wfull;
      logic [3:0] gnt;
      logic       winc;
      logic [7:0] wdata;
      logic       chk_ptr;
      logic [1:0] ptr;
   } vec_t;

   vec_t       tab[$];
   vec_t       sb_q[$];
   logic [7:0] cnt [N];
   logic [7:0] wr_log[$];
   logic [7:0] exp_log[$];
   int         checks;
   int         failures;
   string      tname;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester i presents word i*16 + (number of its words accepted so far).
   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(i * 16) + cnt[i];
   end

   // Words that actually enter the FIFO.
   always @(posedge clk) if (rstn && winc) wr_log.push_back(wdata);

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s actual=%0h required=%0h", tname, nm, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] r, input logic f, input logic [3:0] g,
                      input logic w, input logic [7:0] d);
      vec_t v;
      v.req = r; v.wfull = f; v.gnt = g; v.winc = w; v.wdata = d;
      v.chk_ptr = 1'b0; v.ptr = 2'd0;
      tab.push_back(v);
   endtask

   task automatic want_ptr(input logic [1:0] p);
      tab[tab.size()-1].chk_ptr = 1'b1;
      tab[tab.size()-1].ptr     = p;
   endtask

   // Drive one cycle just after posedge, check at negedge, advance acked data.
   task automatic apply(input vec_t v);
      vec_t       e;
      logic [3:0] a;
      req   = v.req;
      wfull = v.wfull;
      sb_q.push_back(v);
      @(negedge clk);
      e = sb_q.pop_front();
      chk("gnt",  32'(gnt),  32'(e.gnt));
      chk("winc", 32'(winc), 32'(e.winc));
      chk("ack",  32'(ack),  e.winc ? 32'(e.gnt) : 32'd0);
      chk("busy", 32'(busy), 32'(e.gnt != 4'b0));
      if (e.winc) chk("wdata", 32'(wdata), 32'(e.wdata));
      if (e.chk_ptr) chk("rr_ptr", 32'(dut.rr_ptr), 32'(e.ptr));
      a = ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (a[i]) cnt[i] = cnt[i] + 8'd1;
   endtask

   task automatic run_tab();
      for (int i = 0; i < tab.size(); i++) apply(tab[i]);
      tab.delete();
   endtask

   task automatic chk_log();
      chk("log_size", 32'(wr_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++)
         chk("log_word", 32'(wr_log[i]), 32'(exp_log[i]));
      exp_log.delete();
   endtask

   // Hold reset for two cycles with request vector r, checking outputs stay quiet.
   task automatic do_reset(input logic [3:0] r);
      rstn  = 1'b0;
      req   = r;
      wfull = 1'b0;
      for (int i = 0; i < N; i++) cnt[i] = 8'd0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_gnt",   32'(gnt),   32'd0);
         chk("rst_winc",  32'(winc),  32'd0);
         chk("rst_ack",   32'(ack),   32'd0);
         chk("rst_busy",  32'(busy),  32'd0);
         chk("rst_wdata", 32'(wdata), 32'd0);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      wr_log.delete();
   endtask

   initial begin
      checks = 0; failures = 0;
      rstn = 1'b0; req = '0; wfull = 1'b0;
      for (int i = 0; i < N; i++) cnt[i] = 8'd0;
      @(posedge clk);
      #1;

      // Reset with every requester asking, then round-robin fairness.
      tname = "reset";
      do_reset(4'b1111);
      tname = "fair";
      add(4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00);
      for (int b = 0; b < 5; b++)
         for (int w = 0; w < 4; w++)
            add(4'b1111, 1'b0, 4'(1 << (b % 4)), 1'b1, 8'((b % 4) * 16 + (b / 4) * 4 + w));
      run_tab();

      // Single requester keeps the grant across the burst boundary.
      tname = "single";
      do_reset(4'b0010);
      add(4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00);
      for (int k = 0; k < 8; k++) add(4'b0010, 1'b0, 4'b0010, 1'b1, 8'(8'h10 + k));
      add(4'b0000, 1'b0, 4'b0010, 1'b0, 8'h00);
      add(4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00);
      run_tab();
      for (int k = 0; k < 8; k++) exp_log.push_back(8'(8'h10 + k));
      chk_log();

      // Back-pressure: full for three cycles in the middle of a burst.
      tname = "bp";
      do_reset(4'b0100);
      add(4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00);
      add(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h20);
      add(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h21);
      for (int k = 0; k < 3; k++) add(4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00);
      add(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h22);
      add(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h23);
      add(4'b0000, 1'b1, 4'b0100, 1'b0, 8'h00);
      add(4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00);
      run_tab();
      for (int k = 0; k < 4; k++) exp_log.push_back(8'(8'h20 + k));
      chk_log();

      // Early release hands over to requester 3 with no idle cycle.
      tname = "early";
      do_reset(4'b1001);
      add(4'b1001, 1'b0, 4'b0000, 1'b0, 8'h00);
      add(4'b1001, 1'b0, 4'b0001, 1'b1, 8'h00);
      add(4'b1001, 1'b0, 4'b0001, 1'b1, 8'h01);
      add(4'b1000, 1'b0, 4'b0001, 1'b0, 8'h00);
      add(4'b1000, 1'b0, 4'b1000, 1'b1, 8'h30);
      want_ptr(2'd1);
      add(4'b1000, 1'b0, 4'b1000, 1'b1, 8'h31);
      add(4'b1000, 1'b0, 4'b1000, 1'b1, 8'h32);
      add(4'b1000, 1'b0, 4'b1000, 1'b1, 8'h33);
      add(4'b0000, 1'b0, 4'b1000, 1'b0, 8'h00);
      want_ptr(2'd0);
      add(4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00);
      run_tab();

      // Asynchronous reset between clock edges in the middle of a burst.
      tname = "async";
      do_reset(4'b0010);
      add(4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00);
      add(4'b0010, 1'b0, 4'b0010, 1'b1, 8'h10);
      add(4'b0010, 1'b0, 4'b0010, 1'b1, 8'h11);
      run_tab();
      #2;
      chk("pre_gnt",  32'(gnt),  32'h2);
      chk("pre_winc", 32'(winc), 32'd1);
      rstn = 1'b0;
      #1;
      chk("now_gnt",  32'(gnt),  32'd0);
      chk("now_winc", 32'(winc), 32'd0);
      chk("now_ack",  32'(ack),  32'd0);
      chk("now_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("held_gnt", 32'(gnt), 32'd0);
      rstn = 1'b1;
      exp_log.push_back(8'h10);
      exp_log.push_back(8'h11);
      chk_log();
      add(4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00);
      add(4'b0010, 1'b0, 4'b0010, 1'b1, 8'h12);
      add(4'b0000, 1'b0, 4'b0010, 1'b0, 8'h00);
      add(4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00);
      run_tab();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of an asyn_fifo among NUM_REQ requesters, all in the FIFO's write-clock domain.
- Uses round-robin arbitration with bounded bursts. One requester owns the port until MAX_BURST words are accepted or it drops its request.
- Drives winc/wdata into the FIFO and respects wfull back-pressure.
- Purely single-clock; the FIFO handles the clock crossing.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- WIDTH, 8, data word width; must equal the FIFO WIDTH
- MAX_BURST, 4, maximum words per grant (>=1)

Ports:
- clk  in  1  clock; connects to the FIFO wclk
- rstn  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request; level, one bit per requester
- req_data  in  NUM_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH]
- ack  out  NUM_REQ  word of requester i accepted this cycle (combinational)
- gnt  out  NUM_REQ  registered one-hot grant; all-zero when idle
- wfull  in  1  FIFO full flag
- winc  out  1  FIFO write enable
- wdata  out  WIDTH  FIFO write data
- busy  out  1  high while in BURST

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rstn is asynchronous and active-low.
  - Reset values: state=IDLE, gnt=0, rr_ptr=0, burst_cnt=0.
  - Consequently winc=0, ack=0, busy=0, wdata=0.
- Requester protocol:
  - req_data[i] is valid whenever req[i]=1.
  - req_data[i] must advance to the next word on the cycle after ack[i].
  - req[i] may deassert at any time.
- State IDLE:
  - If req!=0, pick the first set bit searching circularly from rr_ptr upward (rr_ptr, rr_ptr+1, ..., wrapping).
  - Register the one-hot gnt and clear burst_cnt, then go to BURST.
  - Grant latency is 1 cycle after req is seen. No write occurs in IDLE.
- State BURST (owner = index of gnt):
  - winc = req[owner] & ~wfull.
  - wdata = req_data[owner].
  - ack = gnt when winc=1, else 0.
  - burst_cnt (width clog2(MAX_BURST+1)) increments on each winc.
- Burst end occurs when either:
  - (a) winc=1 and burst_cnt==MAX_BURST-1, or
  - (b) req[owner]=0 (no write that cycle).
- On burst end:
  - rr_ptr <= owner+1, mod NUM_REQ.
  - Re-arbitrate in the same cycle from owner+1 over the current req vector. For case (a), req[owner] counts; for (b) it is 0.
  - If a winner exists, gnt is loaded directly and burst_cnt cleared, staying in BURST with no idle cycle. Otherwise go to IDLE with gnt=0.
  - If the owner is the only requester, it is re-granted back-to-back.
- wfull=1 in BURST:
  - winc=0 and burst_cnt is held.
  - gnt is held with no timeout.
  - If req[owner] drops while full, rule (b) applies.
- Non-owner requests are ignored during a burst; no preemption.
- Writes are only ever issued while wfull=0.
- Reset asserted mid-burst:
  - All state clears immediately; the in-flight burst is abandoned.
  - Words already written remain in the FIFO. The requester re-requests after reset.
- Invariants:
  - gnt is always one-hot or zero.
  - At most one ack bit is set per cycle.
  - winc == |ack.

Test Plan:
- Reset: assert rstn=0 with req=4'b1111 and wfull=0 -> gnt=0, winc=0, ack=0, busy=0 throughout. First gnt=4'b0001 appears one cycle after rstn rises.
- Single requester: req=4'b0010 held, data 0x10,0x11,... -> gnt=4'b0010 at cycle 1, then winc=1 on 8 consecutive cycles writing 0x10..0x17. gnt stays 4'b0010 across the burst boundary with no gap.
- Fairness: req=4'b1111 held with wfull=0 -> grants go 0,1,2,3,0, each for exactly 4 writes, with no idle cycles between bursts. Each ack bit pulses 4 times per 16 cycles.
- Back-pressure: req2 owns the grant; after 2 writes, hold wfull=1 for 3 cycles -> winc=0 and gnt=4'b0100 held for 3 cycles. The burst then completes with exactly 2 more writes.
- Early release: req=4'b1001 with req0 owning; req0 drops after 2 writes -> next cycle gnt=4'b1000 and rr_ptr=1. req3 gets a full 4-word burst.
- Async reset mid-burst: pulse rstn low between clock edges during a req1 burst -> gnt and winc go to 0 immediately. The FIFO holds exactly the words acked before reset.
